// File: rtl/seq_code_lock_if.sv
// Symbol-entry and status bundle for seq_code_lock.
// The master side supplies the code, symbols and clear; the slave side
// (the lock itself) returns state, progress, status flags and fail count.
interface seq_code_lock_if #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int MAX_FAIL = 3
);
    localparam int PW = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1;
    localparam int FW = ($clog2(MAX_FAIL + 1) > 1) ? $clog2(MAX_FAIL + 1) : 1;

    logic [WIDTH*DEPTH-1:0] code;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   clear;
    logic [2:0]             state;
    logic [PW-1:0]          progress;
    logic                   unlocked;
    logic                   error;
    logic                   locked_out;
    logic [FW-1:0]          fail_count;

    modport master (
        output code, in_valid, in_data, clear,
        input  state, progress, unlocked, error, locked_out, fail_count
    );

    modport slave (
        input  code, in_valid, in_data, clear,
        output state, progress, unlocked, error, locked_out, fail_count
    );
endinterface

// File: rtl/seq_code_lock.sv
// Sequential code lock: checks a stream of symbols against a DEPTH-symbol
// code, reports progress/open/error, counts consecutive failed attempts and
// enforces a timed lockout once MAX_FAIL failures accumulate.
module seq_code_lock #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             reset,
    seq_code_lock_if.slave  bus
);
    localparam int PW = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1;
    localparam int FW = ($clog2(MAX_FAIL + 1) > 1) ? $clog2(MAX_FAIL + 1) : 1;
    localparam int TW = ($clog2(LOCKOUT_CYCLES) > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_ERROR   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    prog_q, prog_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             unlocked_q, error_q, locked_q;
    logic [WIDTH-1:0] cur_sym;

    // Select the code symbol expected at the current progress position.
    always_comb begin
        cur_sym = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (prog_q == PW'(k)) begin
                cur_sym = bus.code[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state, progress, failure count and lockout timer.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE, S_CHECK: begin
                // clear takes priority; an abandoned attempt is not a failure
                if (bus.clear) begin
                    state_d = S_IDLE;
                    prog_d  = '0;
                end else if (bus.in_valid) begin
                    if (bus.in_data == cur_sym) begin
                        if (prog_q == PW'(DEPTH - 1)) begin
                            state_d = S_OPEN;
                            prog_d  = PW'(DEPTH);
                            fail_d  = '0;
                        end else begin
                            state_d = S_CHECK;
                            prog_d  = prog_q + PW'(1);
                        end
                    end else if (fail_q >= FW'(MAX_FAIL - 1)) begin
                        state_d = S_LOCKOUT;
                        fail_d  = FW'(MAX_FAIL);
                        timer_d = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = S_ERROR;
                        fail_d  = fail_q + FW'(1);
                    end
                end
            end
            S_OPEN, S_ERROR: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                    prog_d  = '0;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    prog_d  = '0;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                prog_d  = '0;
            end
        endcase
    end

    // State and output registers; flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            prog_q     <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            unlocked_q <= (state_d == S_OPEN);
            error_q    <= (state_d == S_ERROR);
            locked_q   <= (state_d == S_LOCKOUT);
        end
    end

    assign bus.state      = state_q;
    assign bus.progress   = prog_q;
    assign bus.fail_count = fail_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.error      = error_q;
    assign bus.locked_out = locked_q;
endmodule

// File: doc/seq_code_lock.md
Name: seq_code_lock

Overview:
- Parametrised, clocked successor of the team's combinational code-check circuit.
- Accepts a stream of WIDTH-bit symbols and checks them in order against a DEPTH-symbol code.
- Reports progress, open, error and lockout status.
- Consecutive failures are counted; reaching the limit forces a timed lockout. Sits between the keypad/input decoder and the actuator/status logic.

Parameters:
- WIDTH, 8, bits per symbol.
- DEPTH, 4, number of symbols in the code (>=2).
- MAX_FAIL, 3, consecutive wrong attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT (>=1).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; reset=0 clears all state.
- code  in  WIDTH*DEPTH  expected code, quasi-static. Symbol k is code[k*WIDTH +: WIDTH]; symbol 0 is entered first.
- in_valid  in  1  in_data holds a symbol this cycle.
- in_data  in  WIDTH  entered symbol.
- clear  in  1  soft return to IDLE from OPEN or ERROR.
- state  out  3  IDLE=0, CHECK=1, OPEN=2, ERROR=3, LOCKOUT=4.
- progress  out  max(1,$clog2(DEPTH+1))  symbols matched so far in the current attempt.
- unlocked  out  1  high while in OPEN.
- error  out  1  high while in ERROR.
- locked_out  out  1  high while in LOCKOUT.
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive failed attempts.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, progress=0, fail_count=0, timer=0. All flags are 0 from the next cycle.
- Reset overrides every other input, in any state, including mid-attempt and mid-lockout.
- All outputs are registered. A response to the input sampled at edge n is visible after edge n.
- Outputs decode directly from state: unlocked=(state==OPEN), error=(state==ERROR), locked_out=(state==LOCKOUT).
- Comparison (IDLE/CHECK, in_valid=1, clear=0): in_data is compared with symbol[progress].
  - Match, progress<DEPTH-1: progress+1, state=CHECK.
  - Match, progress==DEPTH-1: state=OPEN, progress=DEPTH, fail_count=0.
  - Mismatch, fail_count+1<MAX_FAIL: state=ERROR, fail_count+1, progress held at its value.
  - Mismatch, fail_count+1==MAX_FAIL: state=LOCKOUT, fail_count=MAX_FAIL, timer=LOCKOUT_CYCLES-1.
- in_valid=0 in IDLE/CHECK: hold. There is no inactivity timeout.
- OPEN: in_valid ignored. clear=1 -> IDLE, progress=0.
- ERROR: sticky. in_valid ignored. clear=1 -> IDLE, progress=0, fail_count retained.
- LOCKOUT: in_valid and clear ignored. Timer decrements each cycle.
  - Transition out occurs on the edge where timer==0: state=IDLE, progress=0, fail_count=0.
  - Exactly LOCKOUT_CYCLES cycles are spent in LOCKOUT.
- clear and in_valid both high in IDLE/CHECK: clear wins, progress=0, symbol discarded, fail_count unchanged.
  - An abandoned partial attempt is not counted as a failure.
- fail_count never exceeds MAX_FAIL and never wraps.
- code changes take effect at the next comparison. No shadow copy is kept.
- Illegal state encodings (5-7) -> IDLE, progress=0, on the next edge.

Test Plan:
- Reset and basic pass: hold reset=0 two cycles -> state=0, all flags 0. Apply code {0x9C,0xD8,0xEB,0x9F} symbol 0 first. Send 0x9C,0xD8,0xEB,0x9F on consecutive cycles -> progress 1,2,3, then state=2, unlocked=1, fail_count=0.
- Error and clear: send 0x9C then 0xD1 -> state=3, error=1, progress=1, fail_count=1. Further in_valid is ignored. Pulse clear -> state=0, progress=0, fail_count stays 1.
- Lockout: three failed attempts, each cleared -> after the third mismatch state=4, fail_count=3. Stays exactly 16 cycles ignoring in_valid/clear, then state=0, fail_count=0.
- Simultaneous events: clear=1 with in_valid=1, in_data=0xD8 at progress=1 -> progress=0, state=0, fail_count unchanged.
- Reset mid-operation: assert reset=0 during LOCKOUT (timer=7) and during CHECK (progress=2) -> next edge state=0, progress=0, fail_count=0.
- Parameter sweep: WIDTH=4, DEPTH=6, MAX_FAIL=1, LOCKOUT_CYCLES=1.
  - Correct 6-symbol entry -> OPEN.
  - Single mismatch -> LOCKOUT for exactly 1 cycle, then IDLE.
